// File: rtl/mem_req_arbiter.sv
// Arbitrates the fetch port and the load/store buffer onto the single memory engine.
// Requests are latched for the whole transaction, and the completion is returned to the owner as a one-cycle pulse.
module mem_req_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_inst,
  input  logic        lsb_req_valid,
  input  logic        lsb_req_is_write,
  input  logic [31:0] lsb_req_addr,
  input  logic [2:0]  lsb_req_len,
  input  logic [31:0] lsb_req_wdata,
  output logic        lsb_resp_valid,
  output logic [31:0] lsb_resp_data,
  output logic        mc_valid,
  output logic        mc_is_write,
  output logic [31:0] mc_addr,
  output logic [2:0]  mc_len,
  output logic [31:0] mc_wdata,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_LSB,
    DRAIN
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_n;
  logic              mc_valid_n, mc_is_write_n;
  logic [31:0]       mc_addr_n, mc_wdata_n;
  logic [2:0]        mc_len_n;
  logic              if_resp_valid_n, lsb_resp_valid_n;
  logic [31:0]       if_resp_inst_n, lsb_resp_data_n;

  logic if_elig, lsb_elig, force_if, grant_if, grant_lsb;

  // A requester whose response is on the wire this cycle is still holding the old request.
  assign if_elig   = if_req_valid  && !if_resp_valid;
  assign lsb_elig  = lsb_req_valid && !lsb_resp_valid;
  assign force_if  = (STARVE_LIMIT != 0) && (starve_cnt >= CNT_MAX);
  assign grant_if  = if_elig && (!lsb_elig || force_if);
  assign grant_lsb = lsb_elig && !grant_if;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      mc_valid       <= 1'b0;
      mc_is_write    <= 1'b0;
      mc_addr        <= '0;
      mc_len         <= '0;
      mc_wdata       <= '0;
      if_resp_valid  <= 1'b0;
      if_resp_inst   <= '0;
      lsb_resp_valid <= 1'b0;
      lsb_resp_data  <= '0;
    end else begin
      state          <= state_n;
      starve_cnt     <= starve_cnt_n;
      mc_valid       <= mc_valid_n;
      mc_is_write    <= mc_is_write_n;
      mc_addr        <= mc_addr_n;
      mc_len         <= mc_len_n;
      mc_wdata       <= mc_wdata_n;
      if_resp_valid  <= if_resp_valid_n;
      if_resp_inst   <= if_resp_inst_n;
      lsb_resp_valid <= lsb_resp_valid_n;
      lsb_resp_data  <= lsb_resp_data_n;
    end
  end

  // Every register holds by default so that rdy=0 freezes the whole block.
  always_comb begin
    state_n          = state;
    starve_cnt_n     = starve_cnt;
    mc_valid_n       = mc_valid;
    mc_is_write_n    = mc_is_write;
    mc_addr_n        = mc_addr;
    mc_len_n         = mc_len;
    mc_wdata_n       = mc_wdata;
    if_resp_valid_n  = if_resp_valid;
    if_resp_inst_n   = if_resp_inst;
    lsb_resp_valid_n = lsb_resp_valid;
    lsb_resp_data_n  = lsb_resp_data;

    if (rdy) begin
      if_resp_valid_n  = 1'b0;
      lsb_resp_valid_n = 1'b0;
      if (clear) begin
        starve_cnt_n = '0;
      end

      unique case (state)
        IDLE: begin
          if (!clear) begin
            if (grant_if) begin
              state_n       = BUSY_IF;
              starve_cnt_n  = '0;
              mc_valid_n    = 1'b1;
              mc_is_write_n = 1'b0;
              mc_addr_n     = if_req_addr;
              mc_len_n      = 3'd4;
              mc_wdata_n    = '0;
            end else if (grant_lsb) begin
              state_n       = BUSY_LSB;
              mc_valid_n    = 1'b1;
              mc_is_write_n = lsb_req_is_write;
              mc_addr_n     = lsb_req_addr;
              mc_len_n      = lsb_req_len;
              mc_wdata_n    = lsb_req_wdata;
              if (if_req_valid && (starve_cnt != CNT_MAX)) begin
                starve_cnt_n = starve_cnt + CNT_W'(1);
              end
            end
          end
        end

        BUSY_IF: begin
          if (mc_done) begin
            state_n    = IDLE;
            mc_valid_n = 1'b0;
            if (!clear) begin
              if_resp_valid_n = 1'b1;
              if_resp_inst_n  = mc_rdata;
            end
          end else if (clear) begin
            state_n = DRAIN;
          end
        end

        BUSY_LSB: begin
          if (mc_done) begin
            state_n    = IDLE;
            mc_valid_n = 1'b0;
            if (!clear) begin
              lsb_resp_valid_n = 1'b1;
              lsb_resp_data_n  = mc_is_write ? 32'h0 : mc_rdata;
            end
          end else if (clear) begin
            state_n = DRAIN;
          end
        end

        // A flushed transaction still runs to completion in the engine; its result is dropped.
        DRAIN: begin
          if (mc_done) begin
            state_n    = IDLE;
            mc_valid_n = 1'b0;
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter.
// A directed vector table is followed by randomized traffic that is checked against a transaction-level reference model.
module tb_mem_req_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst;
  logic        lsb_req_valid, lsb_req_is_write;
  logic [31:0] lsb_req_addr, lsb_req_wdata;
  logic [2:0]  lsb_req_len;
  logic        lsb_resp_valid;
  logic [31:0] lsb_resp_data;
  logic        mc_valid, mc_is_write;
  logic [31:0] mc_addr, mc_wdata;
  logic [2:0]  mc_len;
  logic        mc_done;
  logic [31:0] mc_rdata;

  always #5 clk = ~clk;

  mem_req_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst),
    .lsb_req_valid(lsb_req_valid), .lsb_req_is_write(lsb_req_is_write),
    .lsb_req_addr(lsb_req_addr), .lsb_req_len(lsb_req_len), .lsb_req_wdata(lsb_req_wdata),
    .lsb_resp_valid(lsb_resp_valid), .lsb_resp_data(lsb_resp_data),
    .mc_valid(mc_valid), .mc_is_write(mc_is_write), .mc_addr(mc_addr),
    .mc_len(mc_len), .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  typedef struct {
    int          n;
    logic        rst, rdy, clr, ifv;
    logic [31:0] ifa;
    logic        lv, lw;
    logic [31:0] la;
    logic [2:0]  ll;
    logic [31:0] lwd;
    logic        done;
    logic [31:0] rdata;
    logic        mv, mw;
    logic [31:0] ma;
    logic [2:0]  ml;
    logic [31:0] mwd;
    logic        irv;
    logic [31:0] iri;
    logic        lrv;
    logic [31:0] lrd;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model state: who owns the engine, whether its result is being discarded, and the expected outputs.
  int          m_owner;
  bit          m_drain;
  int          m_cnt;
  logic        m_mv, m_mw, m_irv, m_lrv;
  logic [31:0] m_ma, m_mwd, m_iri, m_lrd;
  logic [2:0]  m_ml;

  task automatic addVec(input int n, input logic r, rd, cl, iv, input logic [31:0] ia,
                        input logic lvv, lww, input logic [31:0] laa, input logic [2:0] lll,
                        input logic [31:0] lwdd, input logic dn, input logic [31:0] rdt,
                        input logic mv, mw, input logic [31:0] ma, input logic [2:0] ml,
                        input logic [31:0] mwd, input logic irv, input logic [31:0] iri,
                        input logic lrv, input logic [31:0] lrd);
    vec_t v;
    v.n = n; v.rst = r; v.rdy = rd; v.clr = cl; v.ifv = iv; v.ifa = ia;
    v.lv = lvv; v.lw = lww; v.la = laa; v.ll = lll; v.lwd = lwdd;
    v.done = dn; v.rdata = rdt;
    v.mv = mv; v.mw = mw; v.ma = ma; v.ml = ml; v.mwd = mwd;
    v.irv = irv; v.iri = iri; v.lrv = lrv; v.lrd = lrd;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; rdy = v.rdy; clear = v.clr;
    if_req_valid = v.ifv; if_req_addr = v.ifa;
    lsb_req_valid = v.lv; lsb_req_is_write = v.lw; lsb_req_addr = v.la;
    lsb_req_len = v.ll; lsb_req_wdata = v.lwd;
    mc_done = v.done; mc_rdata = v.rdata;
  endtask

  task automatic checkOutput(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s %s: got %h, expected %h", tag, name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic mv, mw, input logic [31:0] ma,
                          input logic [2:0] ml, input logic [31:0] mwd, input logic irv,
                          input logic [31:0] iri, input logic lrv, input logic [31:0] lrd);
    checkOutput(tag, "mc_valid", 32'(mc_valid), 32'(mv));
    checkOutput(tag, "mc_is_write", 32'(mc_is_write), 32'(mw));
    checkOutput(tag, "mc_addr", mc_addr, ma);
    checkOutput(tag, "mc_len", 32'(mc_len), 32'(ml));
    checkOutput(tag, "mc_wdata", mc_wdata, mwd);
    checkOutput(tag, "if_resp_valid", 32'(if_resp_valid), 32'(irv));
    checkOutput(tag, "if_resp_inst", if_resp_inst, iri);
    checkOutput(tag, "lsb_resp_valid", 32'(lsb_resp_valid), 32'(lrv));
    checkOutput(tag, "lsb_resp_data", lsb_resp_data, lrd);
  endtask

  // One clock edge of the reference model, evaluated from the inputs present at that edge.
  task automatic modelStep();
    logic irv_old, lrv_old;
    bit   ie, le;
    if (rst) begin
      m_owner = 0; m_drain = 0; m_cnt = 0;
      m_mv = 0; m_mw = 0; m_ma = 0; m_ml = 0; m_mwd = 0;
      m_irv = 0; m_iri = 0; m_lrv = 0; m_lrd = 0;
      return;
    end
    if (!rdy) return;
    irv_old = m_irv;
    lrv_old = m_lrv;
    m_irv = 0;
    m_lrv = 0;
    if (m_owner == 0) begin
      if (!clear) begin
        ie = if_req_valid && !irv_old;
        le = lsb_req_valid && !lrv_old;
        if (ie && (!le || (STARVE_LIMIT > 0 && m_cnt >= STARVE_LIMIT))) begin
          m_owner = 1; m_cnt = 0;
          m_mv = 1; m_mw = 0; m_ma = if_req_addr; m_ml = 3'd4; m_mwd = 0;
        end else if (le) begin
          m_owner = 2;
          m_mv = 1; m_mw = lsb_req_is_write; m_ma = lsb_req_addr;
          m_ml = lsb_req_len; m_mwd = lsb_req_wdata;
          if (if_req_valid) m_cnt = (m_cnt + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_cnt + 1;
        end
      end
    end else if (mc_done) begin
      m_mv = 0;
      if (!m_drain && !clear) begin
        if (m_owner == 1) begin
          m_irv = 1; m_iri = mc_rdata;
        end else begin
          m_lrv = 1; m_lrd = m_mw ? 32'h0 : mc_rdata;
        end
      end
      m_owner = 0;
      m_drain = 0;
    end else if (clear) begin
      m_drain = 1;
    end
    if (clear) m_cnt = 0;
  endtask

  task automatic driveRandom(input bit force_rst);
    logic [2:0] lens[3];
    lens[0] = 3'd1; lens[1] = 3'd2; lens[2] = 3'd4;
    rst   = force_rst || ($urandom_range(0, 299) == 0);
    rdy   = ($urandom_range(0, 9) < 8);
    clear = ($urandom_range(0, 19) == 0);
    if (if_req_valid) begin
      if (if_resp_valid || (clear && $urandom_range(0, 1) == 0)) begin
        if ($urandom_range(0, 1) == 1) if_req_valid = 0;
        else if_req_addr = $urandom;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      if_req_valid = 1; if_req_addr = $urandom;
    end
    if (lsb_req_valid) begin
      if (lsb_resp_valid || (clear && $urandom_range(0, 1) == 0)) begin
        if ($urandom_range(0, 1) == 1) lsb_req_valid = 0;
        else begin
          lsb_req_is_write = 1'($urandom_range(0, 1)); lsb_req_addr = $urandom;
          lsb_req_len = lens[$urandom_range(0, 2)]; lsb_req_wdata = $urandom;
        end
      end
    end else if ($urandom_range(0, 2) == 0) begin
      lsb_req_valid = 1; lsb_req_is_write = 1'($urandom_range(0, 1)); lsb_req_addr = $urandom;
      lsb_req_len = lens[$urandom_range(0, 2)]; lsb_req_wdata = $urandom;
    end
    mc_done  = mc_valid ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
    mc_rdata = $urandom;
  endtask

  task automatic buildVecs();
    // n, rst,rdy,clr, ifv,ifa, lv,lw,la,ll,lwd, done,rdata | mv,mw,ma,ml,mwd, irv,iri, lrv,lrd
    addVec(2, 1,1,0, 0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0, 0,0, 0,0);
    addVec(1, 0,1,0, 1,32'h1000, 0,0,0,0,0, 0,0, 1,0,32'h1000,4,0, 0,0, 0,0);
    addVec(4, 0,1,0, 1,32'h1000, 0,0,0,0,0, 0,0, 1,0,32'h1000,4,0, 0,0, 0,0);
    addVec(1, 0,1,0, 1,32'h1000, 0,0,0,0,0, 1,32'h00A00093, 0,0,32'h1000,4,0, 1,32'h00A00093, 0,0);
    addVec(1, 0,1,0, 0,0, 0,0,0,0,0, 0,0, 0,0,32'h1000,4,0, 0,32'h00A00093, 0,0);
    addVec(1, 0,1,0, 0,0, 1,1,32'h30000,1,32'h41, 0,0, 1,1,32'h30000,1,32'h41, 0,32'h00A00093, 0,0);
    addVec(2, 0,1,0, 0,0, 1,1,32'h30000,1,32'h41, 0,0, 1,1,32'h30000,1,32'h41, 0,32'h00A00093, 0,0);
    addVec(1, 0,1,0, 0,0, 1,1,32'h30000,1,32'h41, 1,32'hDEADBEEF, 0,1,32'h30000,1,32'h41, 0,32'h00A00093, 1,0);
    addVec(1, 0,1,0, 0,0, 0,0,0,0,0, 0,0, 0,1,32'h30000,1,32'h41, 0,32'h00A00093, 0,0);
    addVec(1, 0,1,0, 0,0, 1,0,32'h40002,2,32'hFFFF, 0,0, 1,0,32'h40002,2,32'hFFFF, 0,32'h00A00093, 0,0);
    addVec(1, 0,1,0, 0,0, 1,0,32'h40002,2,32'hFFFF, 1,32'hBEEF, 0,0,32'h40002,2,32'hFFFF, 0,32'h00A00093, 1,32'hBEEF);
    addVec(1, 0,1,0, 0,0, 0,0,0,0,0, 0,0, 0,0,32'h40002,2,32'hFFFF, 0,32'h00A00093, 0,32'hBEEF);
    // flush two cycles after a fetch grant: the transaction drains silently
    addVec(2, 0,1,0, 1,32'h2000, 0,0,0,0,0, 0,0, 1,0,32'h2000,4,0, 0,32'h00A00093, 0,32'hBEEF);
    addVec(1, 0,1,1, 0,0, 0,0,0,0,0, 0,0, 1,0,32'h2000,4,0, 0,32'h00A00093, 0,32'hBEEF);
    addVec(2, 0,1,0, 0,0, 0,0,0,0,0, 0,0, 1,0,32'h2000,4,0, 0,32'h00A00093, 0,32'hBEEF);
    addVec(2, 0,1,0, 0,0, 0,0,0,0,0, 1,32'h12345678, 0,0,32'h2000,4,0, 0,32'h00A00093, 0,32'hBEEF);
    // flush coincident with completion
    addVec(2, 0,1,0, 1,32'h3000, 0,0,0,0,0, 0,0, 1,0,32'h3000,4,0, 0,32'h00A00093, 0,32'hBEEF);
    addVec(1, 0,1,1, 0,0, 0,0,0,0,0, 1,32'h87654321, 0,0,32'h3000,4,0, 0,32'h00A00093, 0,32'hBEEF);
    addVec(1, 0,1,0, 0,0, 0,0,0,0,0, 0,0, 0,0,32'h3000,4,0, 0,32'h00A00093, 0,32'hBEEF);
    // a still-raised fetch is not regranted in its own response cycle
    addVec(1, 0,1,0, 1,32'h5000, 0,0,0,0,0, 0,0, 1,0,32'h5000,4,0, 0,32'h00A00093, 0,32'hBEEF);
    addVec(1, 0,1,0, 1,32'h5000, 0,0,0,0,0, 1,32'h0BADF00D, 0,0,32'h5000,4,0, 1,32'h0BADF00D, 0,32'hBEEF);
    addVec(1, 0,1,0, 1,32'h5000, 0,0,0,0,0, 0,0, 0,0,32'h5000,4,0, 0,32'h0BADF00D, 0,32'hBEEF);
    addVec(1, 0,1,0, 1,32'h5000, 0,0,0,0,0, 0,0, 1,0,32'h5000,4,0, 0,32'h0BADF00D, 0,32'hBEEF);
    addVec(1, 0,1,0, 0,0, 0,0,0,0,0, 1,32'h13, 0,0,32'h5000,4,0, 1,32'h13, 0,32'hBEEF);
    // contention: LSB wins, then fetch takes the next slot
    addVec(1, 0,1,0, 1,32'h6000, 1,0,32'h7000,4,0, 0,0, 1,0,32'h7000,4,0, 0,32'h13, 0,32'hBEEF);
    addVec(1, 0,1,0, 1,32'h6000, 1,0,32'h7000,4,0, 1,32'h11223344, 0,0,32'h7000,4,0, 0,32'h13, 1,32'h11223344);
    addVec(1, 0,1,0, 1,32'h6000, 1,0,32'h7000,4,0, 0,0, 1,0,32'h6000,4,0, 0,32'h13, 0,32'h11223344);
    addVec(1, 0,1,0, 1,32'h6000, 1,0,32'h7000,4,0, 1,32'h55667788, 0,0,32'h6000,4,0, 1,32'h55667788, 0,32'h11223344);
    addVec(1, 0,1,0, 0,0, 1,0,32'h7000,4,0, 0,0, 1,0,32'h7000,4,0, 0,32'h55667788, 0,32'h11223344);
    addVec(1, 0,1,0, 0,0, 0,0,0,0,0, 1,32'h99AABBCC, 0,0,32'h7000,4,0, 0,32'h55667788, 1,32'h99AABBCC);
    addVec(1, 0,1,0, 0,0, 0,0,0,0,0, 0,0, 0,0,32'h7000,4,0, 0,32'h55667788, 0,32'h99AABBCC);
    // rdy low freezes a busy load, including a completion that arrives while frozen
    addVec(1, 0,1,0, 0,0, 1,0,32'h8000,4,0, 0,0, 1,0,32'h8000,4,0, 0,32'h55667788, 0,32'h99AABBCC);
    addVec(1, 0,0,0, 0,0, 1,0,32'h8000,4,0, 0,0, 1,0,32'h8000,4,0, 0,32'h55667788, 0,32'h99AABBCC);
    addVec(1, 0,0,0, 0,0, 1,0,32'h8000,4,0, 1,32'hFFFFFFFF, 1,0,32'h8000,4,0, 0,32'h55667788, 0,32'h99AABBCC);
    addVec(1, 0,0,0, 0,0, 1,0,32'h8000,4,0, 0,0, 1,0,32'h8000,4,0, 0,32'h55667788, 0,32'h99AABBCC);
    addVec(1, 0,1,0, 0,0, 1,0,32'h8000,4,0, 1,32'hCAFEF00D, 0,0,32'h8000,4,0, 0,32'h55667788, 1,32'hCAFEF00D);
    addVec(1, 0,1,0, 0,0, 0,0,0,0,0, 0,0, 0,0,32'h8000,4,0, 0,32'h55667788, 0,32'hCAFEF00D);
    addVec(1, 0,0,0, 1,32'h9000, 0,0,0,0,0, 0,0, 0,0,32'h8000,4,0, 0,32'h55667788, 0,32'hCAFEF00D);
    // reset mid-fetch, then the held fetch is granted fresh
    addVec(2, 0,1,0, 1,32'h9000, 0,0,0,0,0, 0,0, 1,0,32'h9000,4,0, 0,32'h55667788, 0,32'hCAFEF00D);
    addVec(1, 1,1,0, 1,32'h9000, 0,0,0,0,0, 0,0, 0,0,0,0,0, 0,0, 0,0);
    addVec(1, 0,1,0, 1,32'h9000, 0,0,0,0,0, 0,0, 1,0,32'h9000,4,0, 0,0, 0,0);
    addVec(1, 0,1,0, 1,32'h9000, 0,0,0,0,0, 1,32'h1, 0,0,32'h9000,4,0, 1,32'h1, 0,0);
    addVec(1, 0,1,0, 0,0, 0,0,0,0,0, 0,0, 0,0,32'h9000,4,0, 0,32'h1, 0,0);
    // a flushed store still completes in the engine, but no response is returned
    addVec(1, 0,1,0, 0,0, 1,1,32'hA0000,4,32'h12345678, 0,0, 1,1,32'hA0000,4,32'h12345678, 0,32'h1, 0,0);
    addVec(1, 0,1,1, 0,0, 0,0,0,0,0, 0,0, 1,1,32'hA0000,4,32'h12345678, 0,32'h1, 0,0);
    addVec(1, 0,1,0, 0,0, 0,0,0,0,0, 1,32'h0, 0,1,32'hA0000,4,32'h12345678, 0,32'h1, 0,0);
    addVec(1, 0,1,0, 0,0, 0,0,0,0,0, 0,0, 0,1,32'hA0000,4,32'h12345678, 0,32'h1, 0,0);
  endtask

  initial begin
    rst = 1; rdy = 1; clear = 0;
    if_req_valid = 0; if_req_addr = 0;
    lsb_req_valid = 0; lsb_req_is_write = 0; lsb_req_addr = 0; lsb_req_len = 0; lsb_req_wdata = 0;
    mc_done = 0; mc_rdata = 0;
    buildVecs();
    @(negedge clk);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        applyStimulus(vecs[i]);
        @(posedge clk);
        @(negedge clk);
        checkAll($sformatf("vec%0d.%0d", i, k), vecs[i].mv, vecs[i].mw, vecs[i].ma, vecs[i].ml,
                 vecs[i].mwd, vecs[i].irv, vecs[i].iri, vecs[i].lrv, vecs[i].lrd);
      end
    end

    for (int c = 0; c < 3000; c++) begin
      driveRandom(c == 0);
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkAll($sformatf("rand%0d", c), m_mv, m_mw, m_ma, m_ml, m_mwd, m_irv, m_iri, m_lrv, m_lrd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
